if_id_hazard: RTL and testbench

IF_ID_HAZARD -- requirements
Module: if_id_hazard

---
 rtl/if_id_hazard.sv | 127 ++++++++++++
 tb/tb_if_id_hazard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall detection, branch flush and
// saturating stall/flush performance counters.

module if_id_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module if_id_hazard #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      inst,
  input  logic [63:0]      pc_current,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic [63:0]      branch_target,
  output logic             stall,
  output logic             pc_src,
  output logic [63:0]      b_j_Result,
  output logic [31:0]      id_inst,
  output logic [63:0]      id_pc,
  output logic             id_valid,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int NUM_CNT = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_RST = '{inst: NOP_INST, pc: 64'd0, valid: 1'b0};

  ifid_t ifid_d, ifid_q;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used;
  logic       load_use;

  assign opcode = ifid_q.inst[6:0];
  assign rs1    = ifid_q.inst[19:15];
  assign rs2    = ifid_q.inst[24:20];

  // R/I/load/JALR/store/branch read rs1; only R/store/branch read rs2.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign load_use = ifid_q.valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((rs1_used & (rs1 == ex_rd)) | (rs2_used & (rs2 == ex_rd)));

  // A taken branch squashes the ID instruction, so its hazard is moot.
  assign stall        = load_use & ~branch_taken;
  assign id_ex_bubble = stall | branch_taken;
  assign pc_src       = branch_taken;
  assign b_j_Result   = branch_target;

  always_comb begin
    ifid_d = '{inst: inst, pc: pc_current, valid: 1'b1};
    if (branch_taken) ifid_d = IFID_RST;
    else if (stall)   ifid_d = ifid_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ifid_q <= IFID_RST;
    else          ifid_q <= ifid_d;
  end

  assign id_inst  = ifid_q.inst;
  assign id_pc    = ifid_q.pc;
  assign id_valid = ifid_q.valid;

  logic [NUM_CNT-1:0]            cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_val;

  assign cnt_inc = {branch_taken, stall};

  genvar g;
  generate
    for (g = 0; g < NUM_CNT; g++) begin : g_cnt
      if_id_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (cnt_inc[g]),
        .cnt     (cnt_val[g])
      );
    end
  endgenerate

  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];
endmodule

// File: tb/tb_if_id_hazard.sv
// Directed bench for if_id_hazard: expected snapshots are queued as each step
// is driven and popped when the DUT outputs are sampled.

module tb_if_id_hazard;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI  = 32'h00A2_8293;
  localparam logic [31:0] ADD   = 32'h0062_83B3;
  localparam logic [31:0] LUI   = 32'h0000_52B7;
  localparam logic [31:0] OTHER = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] inst;
  logic [63:0] pc_current;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall, pc_src, id_valid, id_ex_bubble;
  logic [63:0] b_j_Result, id_pc;
  logic [31:0] id_inst;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        valid;
    logic        stall;
    logic        bubble;
    logic        pc_src;
    logic [63:0] bj;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t sb[$];

  logic [31:0] e_inst;
  logic [63:0] e_pc;
  logic        e_valid, e_stall, e_bub, e_src;
  logic [63:0] e_bj;
  logic [15:0] e_scnt, e_fcnt;

  if_id_hazard #(.NOP_INST(NOP), .CNT_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .inst          (inst),
    .pc_current    (pc_current),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .pc_src        (pc_src),
    .b_j_Result    (b_j_Result),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_valid      (id_valid),
    .id_ex_bubble  (id_ex_bubble),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag; e.inst = e_inst; e.pc = e_pc; e.valid = e_valid;
    e.stall = e_stall; e.bubble = e_bub; e.pc_src = e_src; e.bj = e_bj;
    e.scnt = e_scnt; e.fcnt = e_fcnt;
    sb.push_back(e);
  endtask

  task automatic chk1(input string tag, input string fld,
                      input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk1(e.tag, "id_inst",  {32'd0, id_inst},      {32'd0, e.inst});
    chk1(e.tag, "id_pc",    id_pc,                 e.pc);
    chk1(e.tag, "id_valid", {63'd0, id_valid},     {63'd0, e.valid});
    chk1(e.tag, "stall",    {63'd0, stall},        {63'd0, e.stall});
    chk1(e.tag, "bubble",   {63'd0, id_ex_bubble}, {63'd0, e.bubble});
    chk1(e.tag, "pc_src",   {63'd0, pc_src},       {63'd0, e.pc_src});
    chk1(e.tag, "b_j",      b_j_Result,            e.bj);
    chk1(e.tag, "stall_cnt",{48'd0, stall_cnt},    {48'd0, e.scnt});
    chk1(e.tag, "flush_cnt",{48'd0, flush_cnt},    {48'd0, e.fcnt});
  endtask

  task automatic drive(input logic rn, input logic [31:0] i, input logic [63:0] pc,
                       input logic mr, input logic [4:0] rd,
                       input logic bt, input logic [63:0] tgt);
    reset_n = rn; inst = i; pc_current = pc; ex_mem_read = mr; ex_rd = rd;
    branch_taken = bt; branch_target = tgt;
    e_src = bt; e_bj = tgt;
  endtask

  task automatic edge_settle();
    @(posedge clk); #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 64'h0, 1'b0, 5'd0, 1'b1, 64'hDEAD);
    e_inst = NOP; e_pc = 0; e_valid = 0; e_stall = 0; e_bub = 1;
    e_scnt = 0; e_fcnt = 0;
    edge_settle(); edge_settle();
    push("reset_bt"); check();

    // Reset release, first capture.
    drive(1'b1, ADDI, 64'h100, 1'b0, 5'd0, 1'b0, 64'h0);
    #1; e_bub = 0; push("rel_comb"); check();
    edge_settle();
    e_inst = ADDI; e_pc = 64'h100; e_valid = 1; push("cap_addi"); check();

    drive(1'b1, ADD, 64'h104, 1'b0, 5'd0, 1'b0, 64'h0);
    edge_settle();
    e_inst = ADD; e_pc = 64'h104; push("cap_add"); check();

    // rs2 load-use hazard: hold one edge.
    drive(1'b1, OTHER, 64'h108, 1'b1, 5'd6, 1'b0, 64'h0);
    #1; e_stall = 1; e_bub = 1; push("lu_rs2_comb"); check();
    edge_settle();
    e_scnt = 1; push("lu_rs2_hold"); check();

    drive(1'b1, OTHER, 64'h108, 1'b0, 5'd6, 1'b0, 64'h0);
    #1; e_stall = 0; e_bub = 0; push("lu_release"); check();
    edge_settle();
    e_inst = OTHER; e_pc = 64'h108; push("lu_resume"); check();

    drive(1'b1, ADD, 64'h10C, 1'b0, 5'd0, 1'b0, 64'h0);
    edge_settle();
    e_inst = ADD; e_pc = 64'h10C; push("cap_add2"); check();

    // ex_rd == x0 never stalls.
    drive(1'b1, LUI, 64'h110, 1'b1, 5'd0, 1'b0, 64'h0);
    #1; push("rd_zero"); check();
    edge_settle();
    e_inst = LUI; e_pc = 64'h110; push("cap_lui"); check();

    // LUI reads no registers.
    drive(1'b1, ADDI, 64'h114, 1'b1, 5'd5, 1'b0, 64'h0);
    #1; push("lui_nohaz"); check();
    edge_settle();
    e_inst = ADDI; e_pc = 64'h114; e_stall = 1; e_bub = 1;
    push("cap_addi_rs1haz"); check();

    // rs1 hazard holds.
    edge_settle();
    e_scnt = 2; push("lu_rs1_hold"); check();

    // Branch beats load-use.
    drive(1'b1, OTHER, 64'h118, 1'b1, 5'd5, 1'b1, 64'h2000);
    #1; e_stall = 0; e_bub = 1; push("br_prio_comb"); check();
    edge_settle();
    e_inst = NOP; e_pc = 0; e_valid = 0; e_fcnt = 1; push("br_flush"); check();

    // Invalid ID never stalls.
    drive(1'b1, ADD, 64'h2000, 1'b1, 5'd6, 1'b0, 64'h0);
    #1; e_bub = 0; push("inval_nostall"); check();
    edge_settle();
    e_inst = ADD; e_pc = 64'h2000; e_valid = 1; e_stall = 1; e_bub = 1;
    push("cap_after_flush"); check();

    // Saturate stall_cnt with a persistent hazard.
    repeat (65533) @(posedge clk);
    #1; e_scnt = 16'hFFFF; push("sat_reach"); check();
    edge_settle();
    push("sat_hold"); check();

    // Reset mid-stall drops the held instruction.
    drive(1'b0, OTHER, 64'h300, 1'b1, 5'd6, 1'b0, 64'h0);
    #1; push("rst_mid_comb"); check();
    edge_settle();
    e_inst = NOP; e_pc = 0; e_valid = 0; e_stall = 0; e_bub = 0;
    e_scnt = 0; e_fcnt = 0; push("rst_mid"); check();

    drive(1'b1, OTHER, 64'h300, 1'b0, 5'd0, 1'b0, 64'h0);
    edge_settle();
    e_inst = OTHER; e_pc = 64'h300; e_valid = 1; push("post_rst_cap"); check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
